// File: rtl/oled_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oled_rx_pkg
// Brief    : Opcode constants, decoder state encoding and reset defaults for
//            the OLED SPI receiver.
// Revision : 1.0
// ============================================================================
package oled_rx_pkg;

   typedef enum logic [0:0] {
      CMD   = 1'b0,
      PARAM = 1'b1
   } state_t;

   localparam logic [7:0] c_op_disp_off   = 8'hAE;
   localparam logic [7:0] c_op_disp_on    = 8'hAF;
   localparam logic [7:0] c_op_normal     = 8'hA6;
   localparam logic [7:0] c_op_invert     = 8'hA7;
   localparam logic [7:0] c_op_contrast   = 8'h81;
   localparam logic [7:0] c_op_chg_pump   = 8'h8D;
   localparam logic [7:0] c_op_mux_ratio  = 8'hA8;
   localparam logic [7:0] c_op_clk_div    = 8'hD5;
   localparam logic [7:0] c_op_precharge  = 8'hD9;
   localparam logic [7:0] c_op_com_pins   = 8'hDA;
   localparam logic [7:0] c_op_vcomh      = 8'hDB;
   localparam logic [7:0] c_op_addr_mode  = 8'h20;

   localparam logic [7:0] c_def_contrast  = 8'h7F;

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_rx
// Brief    : Synchronizes the SPI pins into CLK, detects SCLK rising edges and
//            assembles bytes MSB first; flags frames cut short by CS.
// Revision : 1.0
// ============================================================================
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CS,
   input  logic       SDIN,
   input  logic       SCLK,
   input  logic       DC,
   output logic [7:0] rx_byte,
   output logic       rx_dc,
   output logic       byte_valid,
   output logic       frame_err
);

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_sdin_sync;
   logic [SYNC_STAGES-1:0] r_dc_sync;
   logic                   r_sclk_prev;
   logic [7:0]             r_shift;
   logic [2:0]             r_cnt;
   logic                   r_frame_err;

   logic w_cs;
   logic w_sclk;
   logic w_sdin;
   logic w_dc;
   logic w_edge;

   // Idle levels (CS and SCLK high) keep a reset from looking like activity.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= '1;
         r_sdin_sync <= '0;
         r_dc_sync   <= '0;
      end else begin
         r_cs_sync[0]   <= CS;
         r_sclk_sync[0] <= SCLK;
         r_sdin_sync[0] <= SDIN;
         r_dc_sync[0]   <= DC;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_sdin_sync[i] <= r_sdin_sync[i-1];
            r_dc_sync[i]   <= r_dc_sync[i-1];
         end
      end
   end

   assign w_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_sdin = r_sdin_sync[SYNC_STAGES-1];
   assign w_dc   = r_dc_sync[SYNC_STAGES-1];

   assign w_edge     = w_sclk && !r_sclk_prev && !w_cs;
   assign rx_byte    = {r_shift[6:0], w_sdin};
   assign rx_dc      = w_dc;
   assign byte_valid = w_edge && (r_cnt == 3'd7);
   assign frame_err  = r_frame_err;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sclk_prev <= 1'b1;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_sclk_prev <= w_sclk;
         r_frame_err <= 1'b0;
         if (w_cs) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_frame_err <= (r_cnt != 3'd0);
         end else if (w_edge) begin
            // Counter wraps 7 -> 0 as the completed byte is handed out.
            r_shift <= {r_shift[6:0], w_sdin};
            r_cnt   <= r_cnt + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_rx
// Brief    : OLED display-side SPI model: decodes commands, tracks panel state
//            and writes data bytes to a page-addressed framebuffer.
// Revision : 1.0
// ============================================================================
module oled_spi_rx
   import oled_rx_pkg::*;
#(
   parameter int NUM_PAGES   = 4,
   parameter int NUM_COLS    = 128,
   parameter int SYNC_STAGES = 2,
   localparam int AW = (NUM_PAGES * NUM_COLS > 1) ? $clog2(NUM_PAGES * NUM_COLS) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CS,
   input  logic          SDIN,
   input  logic          SCLK,
   input  logic          DC,
   output logic          fb_we,
   output logic [AW-1:0] fb_addr,
   output logic [7:0]    fb_wdata,
   output logic          disp_on,
   output logic [7:0]    contrast,
   output logic          chg_pump,
   output logic          invert,
   output logic          cmd_valid,
   output logic [7:0]    cmd_byte,
   output logic          frame_err
);

   localparam int         CW         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int         PW         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
   localparam logic [7:0] c_col_mask = 8'((1 << CW) - 1);

   logic [7:0] w_rx_byte;
   logic       w_rx_dc;
   logic       w_byte_valid;

   spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte_rx (
      .CLK        (CLK),
      .RST        (RST),
      .CS         (CS),
      .SDIN       (SDIN),
      .SCLK       (SCLK),
      .DC         (DC),
      .rx_byte    (w_rx_byte),
      .rx_dc      (w_rx_dc),
      .byte_valid (w_byte_valid),
      .frame_err  (frame_err)
   );

   state_t        r_state,    w_state;
   logic [7:0]    r_opcode,   w_opcode;
   logic [PW-1:0] r_page,     w_page;
   logic [CW-1:0] r_col,      w_col;
   logic          r_disp_on,  w_disp_on;
   logic          r_invert,   w_invert;
   logic          r_chg_pump, w_chg_pump;
   logic [7:0]    r_contrast, w_contrast;

   logic          r_fb_we;
   logic [AW-1:0] r_fb_addr;
   logic [7:0]    r_fb_wdata;
   logic          r_cmd_valid;
   logic [7:0]    r_cmd_byte;

   logic [7:0]    w_col8;
   logic [7:0]    w_col_lo;
   logic [7:0]    w_col_hi;
   logic [CW-1:0] w_col_inc;
   logic [AW-1:0] w_addr;

   function automatic logic [CW-1:0] col_wrap(input logic [7:0] v);
      return CW'(int'(v) % NUM_COLS);
   endfunction

   assign w_col8    = 8'(r_col);
   assign w_col_lo  = {w_col8[7:4], w_rx_byte[3:0]};
   assign w_col_hi  = {w_rx_byte[3:0], w_col8[3:0]} & c_col_mask;
   assign w_col_inc = (r_col == CW'(NUM_COLS - 1)) ? '0 : r_col + 1'b1;
   assign w_addr    = AW'(int'(r_page) * NUM_COLS + int'(r_col));

   always_comb begin
      w_state    = r_state;
      w_opcode   = r_opcode;
      w_page     = r_page;
      w_col      = r_col;
      w_disp_on  = r_disp_on;
      w_invert   = r_invert;
      w_chg_pump = r_chg_pump;
      w_contrast = r_contrast;
      if (w_byte_valid) begin
         if (w_rx_dc) begin
            // Data never moves the decoder; a pending parameter stays pending.
            w_col = w_col_inc;
         end else begin
            case (r_state)
               CMD: begin
                  if (w_rx_byte[7:4] == 4'h0) begin
                     w_col = col_wrap(w_col_lo);
                  end else if (w_rx_byte[7:4] == 4'h1) begin
                     w_col = col_wrap(w_col_hi);
                  end else if (w_rx_byte[7:3] == 5'b10110) begin
                     w_page = PW'(int'(w_rx_byte[2:0]) % NUM_PAGES);
                  end else begin
                     case (w_rx_byte)
                        c_op_disp_off: w_disp_on = 1'b0;
                        c_op_disp_on:  w_disp_on = 1'b1;
                        c_op_normal:   w_invert  = 1'b0;
                        c_op_invert:   w_invert  = 1'b1;
                        c_op_contrast, c_op_chg_pump, c_op_mux_ratio,
                        c_op_clk_div, c_op_precharge, c_op_com_pins,
                        c_op_vcomh, c_op_addr_mode: begin
                           w_opcode = w_rx_byte;
                           w_state  = PARAM;
                        end
                        default: ;
                     endcase
                  end
               end
               PARAM: begin
                  if (r_opcode == c_op_contrast) begin
                     w_contrast = w_rx_byte;
                  end else if (r_opcode == c_op_chg_pump) begin
                     w_chg_pump = w_rx_byte[2];
                  end
                  w_state = CMD;
               end
               default: w_state = CMD;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= CMD;
         r_opcode    <= '0;
         r_page      <= '0;
         r_col       <= '0;
         r_disp_on   <= 1'b0;
         r_invert    <= 1'b0;
         r_chg_pump  <= 1'b0;
         r_contrast  <= c_def_contrast;
         r_fb_we     <= 1'b0;
         r_fb_addr   <= '0;
         r_fb_wdata  <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_byte  <= '0;
      end else begin
         r_state     <= w_state;
         r_opcode    <= w_opcode;
         r_page      <= w_page;
         r_col       <= w_col;
         r_disp_on   <= w_disp_on;
         r_invert    <= w_invert;
         r_chg_pump  <= w_chg_pump;
         r_contrast  <= w_contrast;
         r_fb_we     <= w_byte_valid && w_rx_dc;
         r_cmd_valid <= w_byte_valid && !w_rx_dc;
         if (w_byte_valid && w_rx_dc) begin
            r_fb_addr  <= w_addr;
            r_fb_wdata <= w_rx_byte;
         end
         if (w_byte_valid && !w_rx_dc) begin
            r_cmd_byte <= w_rx_byte;
         end
      end
   end

   assign fb_we     = r_fb_we;
   assign fb_addr   = r_fb_addr;
   assign fb_wdata  = r_fb_wdata;
   assign disp_on   = r_disp_on;
   assign contrast  = r_contrast;
   assign chg_pump  = r_chg_pump;
   assign invert    = r_invert;
   assign cmd_valid = r_cmd_valid;
   assign cmd_byte  = r_cmd_byte;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_spi_rx
// Brief    : Self-checking bench for oled_spi_rx with a write/command scoreboard.
// Revision : 1.0
// ============================================================================
module tb_oled_spi_rx;

   logic       CLK  = 1'b0;
   logic       RST  = 1'b1;
   logic       CS   = 1'b1;
   logic       SDIN = 1'b0;
   logic       SCLK = 1'b1;
   logic       DC   = 1'b0;
   logic       fb_we;
   logic [8:0] fb_addr;
   logic [7:0] fb_wdata;
   logic       disp_on;
   logic [7:0] contrast;
   logic       chg_pump;
   logic       invert;
   logic       cmd_valid;
   logic [7:0] cmd_byte;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;
   int n_err    = 0;
   int n_cmd    = 0;

   logic [7:0]  exp_cmd[$];
   logic [16:0] exp_wr[$];

   oled_spi_rx #(
      .NUM_PAGES   (4),
      .NUM_COLS    (128),
      .SYNC_STAGES (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CS        (CS),
      .SDIN      (SDIN),
      .SCLK      (SCLK),
      .DC        (DC),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .disp_on   (disp_on),
      .contrast  (contrast),
      .chg_pump  (chg_pump),
      .invert    (invert),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte),
      .frame_err (frame_err)
   );

   always #5 CLK = ~CLK;

   // Scoreboard side: every strobe must match the oldest expected entry.
   always @(negedge CLK) begin
      if (!RST) begin
         if (fb_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
               failures++;
               $display("FAIL fb_write unexpected addr=%0d data=%02h", fb_addr, fb_wdata);
            end else begin
               logic [16:0] e;
               e = exp_wr.pop_front();
               if ({fb_addr, fb_wdata} !== e) begin
                  failures++;
                  $display("FAIL fb_write got addr=%0d data=%02h want addr=%0d data=%02h",
                           fb_addr, fb_wdata, e[16:8], e[7:0]);
               end
            end
         end
         if (cmd_valid) begin
            n_cmd++;
            checks++;
            if (exp_cmd.size() == 0) begin
               failures++;
               $display("FAIL cmd_strobe unexpected byte=%02h", cmd_byte);
            end else begin
               logic [7:0] c;
               c = exp_cmd.pop_front();
               if (cmd_byte !== c) begin
                  failures++;
                  $display("FAIL cmd_strobe got %02h want %02h", cmd_byte, c);
               end
            end
         end
         if (frame_err) n_err++;
      end
   end

   task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         SCLK = 1'b0;
         SDIN = b[i];
         DC   = dc;
         #40;
         SCLK = 1'b1;
         #40;
      end
   endtask

   task automatic send_cmd(input logic [7:0] b);
      exp_cmd.push_back(b);
      spi_bits(b, 1'b0, 8);
   endtask

   task automatic send_data(input logic [8:0] addr, input logic [7:0] b);
      exp_wr.push_back({addr, b});
      spi_bits(b, 1'b1, 8);
   endtask

   task automatic cs_low();
      CS = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #100;
      CS = 1'b1;
      #300;
   endtask

   localparam logic [38:0] c_reset_vec = {6'b0, 8'h7F, 9'd0, 8'd0, 8'd0};

   task automatic test_reset();
      logic [38:0] v;
      #23 RST = 1'b0;
      #50;
      v = {fb_we, cmd_valid, frame_err, disp_on, invert, chg_pump,
           contrast, fb_addr, fb_wdata, cmd_byte};
      checks++;
      if (v !== c_reset_vec) begin
         failures++;
         $display("FAIL reset_state got %h want %h", v, c_reset_vec);
      end
   endtask

   task automatic test_single_write();
      cs_low();
      send_cmd(8'hB2);
      send_cmd(8'h15);
      send_cmd(8'h03);
      send_data(9'd339, 8'hA5);
      cs_high();
      checks++;
      if (exp_wr.size() + exp_cmd.size() !== 0) begin
         failures++;
         $display("FAIL single_write pending=%0d want 0", exp_wr.size() + exp_cmd.size());
      end
   endtask

   task automatic test_col_wrap();
      cs_low();
      send_cmd(8'hB0);
      send_cmd(8'h00);
      send_cmd(8'h10);
      for (int i = 0; i < 130; i++) send_data(9'(i % 128), 8'(i));
      cs_high();
      checks++;
      if (exp_wr.size() + exp_cmd.size() !== 0) begin
         failures++;
         $display("FAIL col_wrap pending=%0d want 0", exp_wr.size() + exp_cmd.size());
      end
   endtask

   task automatic test_settings();
      int c0;
      c0 = n_cmd;
      cs_low();
      send_cmd(8'h81);
      send_cmd(8'h3C);
      send_cmd(8'h8D);
      send_cmd(8'h14);
      send_cmd(8'hAF);
      send_cmd(8'hA7);
      cs_high();
      checks++;
      if (contrast !== 8'h3C) begin
         failures++;
         $display("FAIL contrast got %02h want 3c", contrast);
      end
      checks++;
      if (chg_pump !== 1'b1) begin
         failures++;
         $display("FAIL chg_pump got %b want 1", chg_pump);
      end
      checks++;
      if (disp_on !== 1'b1) begin
         failures++;
         $display("FAIL disp_on got %b want 1", disp_on);
      end
      checks++;
      if (invert !== 1'b1) begin
         failures++;
         $display("FAIL invert got %b want 1", invert);
      end
      checks++;
      if (n_cmd - c0 !== 6) begin
         failures++;
         $display("FAIL cmd_count got %0d want 6", n_cmd - c0);
      end
   endtask

   task automatic test_frame_err();
      int e0;
      e0 = n_err;
      cs_low();
      spi_bits(8'hFF, 1'b1, 5);
      cs_high();
      checks++;
      if (n_err - e0 !== 1) begin
         failures++;
         $display("FAIL frame_err_count got %0d want 1", n_err - e0);
      end
      cs_low();
      send_cmd(8'hA6);
      cs_high();
      checks++;
      if (invert !== 1'b0) begin
         failures++;
         $display("FAIL after_err_invert got %b want 0", invert);
      end
      checks++;
      if (exp_wr.size() + exp_cmd.size() !== 0) begin
         failures++;
         $display("FAIL after_err pending=%0d want 0", exp_wr.size() + exp_cmd.size());
      end
   endtask

   task automatic test_data_in_param();
      cs_low();
      send_cmd(8'h81);
      send_data(9'd2, 8'hFF);
      send_cmd(8'h20);
      cs_high();
      checks++;
      if (contrast !== 8'h20) begin
         failures++;
         $display("FAIL param_contrast got %02h want 20", contrast);
      end
      checks++;
      if (exp_wr.size() + exp_cmd.size() !== 0) begin
         failures++;
         $display("FAIL param_data pending=%0d want 0", exp_wr.size() + exp_cmd.size());
      end
   endtask

   task automatic test_reset_mid_byte();
      int          e0;
      logic [38:0] v;
      e0 = n_err;
      cs_low();
      spi_bits(8'hAF, 1'b0, 4);
      #20 RST = 1'b1;
      #30;
      SCLK = 1'b1;
      CS   = 1'b1;
      DC   = 1'b0;
      #17 RST = 1'b0;
      #100;
      v = {fb_we, cmd_valid, frame_err, disp_on, invert, chg_pump,
           contrast, fb_addr, fb_wdata, cmd_byte};
      checks++;
      if (v !== c_reset_vec) begin
         failures++;
         $display("FAIL midbyte_reset_state got %h want %h", v, c_reset_vec);
      end
      checks++;
      if (n_err !== e0) begin
         failures++;
         $display("FAIL midbyte_frame_err got %0d pulses want 0", n_err - e0);
      end
      cs_low();
      send_cmd(8'hAF);
      cs_high();
      checks++;
      if (disp_on !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_disp_on got %b want 1", disp_on);
      end
      checks++;
      if (exp_wr.size() + exp_cmd.size() !== 0) begin
         failures++;
         $display("FAIL post_reset pending=%0d want 0", exp_wr.size() + exp_cmd.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_col_wrap();
      test_settings();
      test_frame_err();
      test_data_in_param();
      test_reset_mid_byte();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
